// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, CTRL/STATUS
// bit positions, animation modes and the run/idle state encoding.
package led_seq_pkg;

  // Word addresses of the Avalon-MM register map
  localparam logic [1:0] ADDR_PATTERN = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_RUN      = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 3;
  localparam int CTRL_IRQ_EN   = 4;

  // STATUS register bit positions
  localparam int STAT_RUNNING = 0;
  localparam int STAT_WRAP    = 1;
  localparam int STAT_DIR     = 2;

  // Animation modes; encodings 5..7 are left undefined and act as static
  typedef enum logic [2:0] {
    MODE_STATIC = 3'd0,
    MODE_ROT_L  = 3'd1,
    MODE_ROT_R  = 3'd2,
    MODE_BOUNCE = 3'd3,
    MODE_BLINK  = 3'd4
  } mode_e;

  // Sequencer state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-period prescaler: counts 0..period while enabled and pulses tick on
// the cycle the count equals period, then restarts from 0. A period of 0
// therefore ticks every enabled cycle. Clear or disable holds the count at 0.
module led_seq_prescaler #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count_q;

  assign tick = en && (count_q == period);

  // Free-running period counter, restarted on clear, idle or terminal count
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr || !en || (count_q == period)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED pattern sequencer. Software loads PATTERN, PERIOD and CTRL;
// the block then rotates, bounces or blinks the pattern on out_port on its
// own, one step per prescaler tick.
// Optional build macro LED_SEQ_IRQ_EN adds an irq output (wrap & CTRL.irq_en)
// and makes CTRL[4] a read/write interrupt enable; without it CTRL[4] reads 0.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int                  WIDTH      = 8,
  parameter int                  PERIOD_W   = 24,
  parameter logic [PERIOD_W-1:0] PERIOD_RST = 24'd5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Software-visible configuration
  logic [WIDTH-1:0]    pattern_q;
  logic [PERIOD_W-1:0] period_q;
  logic                run_q;
  logic [2:0]          mode_q;
  logic                irq_en_q;

  // Animation state
  state_e              state_q;
  logic [WIDTH-1:0]    work_q;
  logic [CNT_W-1:0]    step_cnt_q;
  logic                dir_q;       // 0 = moving left, 1 = moving right
  logic                wrap_q;
  logic                blink_off_q; // 1 while the blink phase shows zeros

  // Bus decode
  logic wr_en, pattern_wr, period_wr, ctrl_wr, status_wr;
  logic cfg_wr, run_start, tick, step;
  logic unused_wdata;

  assign wr_en      = chipselect && !write_n;
  assign pattern_wr = wr_en && (address == ADDR_PATTERN);
  assign period_wr  = wr_en && (address == ADDR_PERIOD);
  assign ctrl_wr    = wr_en && (address == ADDR_CTRL);
  assign status_wr  = wr_en && (address == ADDR_STATUS);

  // Configuration writes take priority over a coincident step
  assign cfg_wr    = pattern_wr || period_wr || ctrl_wr;
  assign run_start = ctrl_wr && writedata[CTRL_RUN] && (state_q == ST_IDLE);
  assign step      = tick && !cfg_wr;

  // Upper writedata bits are not stored by any register
  assign unused_wdata = ^writedata;

  led_seq_prescaler #(
    .PERIOD_W (PERIOD_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q == ST_RUN),
    .clr     (pattern_wr || period_wr || run_start),
    .period  (period_q),
    .tick    (tick)
  );

  // Software register file: PATTERN, PERIOD and CTRL
  // NOTE: every register here is a plain flop (no RAM), so all of it is async-reset to a known value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      period_q  <= PERIOD_RST;
      run_q     <= 1'b0;
      mode_q    <= 3'd0;
      irq_en_q  <= 1'b0;
    end else begin
      if (pattern_wr) pattern_q <= writedata[WIDTH-1:0];
      if (period_wr)  period_q  <= writedata[PERIOD_W-1:0];
      if (ctrl_wr) begin
        run_q  <= writedata[CTRL_RUN];
        mode_q <= writedata[CTRL_MODE_MSB:CTRL_MODE_LSB];
`ifdef LED_SEQ_IRQ_EN
        irq_en_q <= writedata[CTRL_IRQ_EN];
`else
        irq_en_q <= 1'b0;
`endif
      end
    end
  end

  // Run/idle FSM with the working register, step counter, direction and wrap flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      step_cnt_q  <= '0;
      dir_q       <= 1'b0;
      wrap_q      <= 1'b0;
      blink_off_q <= 1'b0;
    end else begin
      // Clear-on-write first so that a wrap event later in this block overrides it
      if (status_wr && writedata[STAT_WRAP]) wrap_q <= 1'b0;

      if (pattern_wr) begin
        work_q      <= writedata[WIDTH-1:0];
        step_cnt_q  <= '0;
        dir_q       <= 1'b0;
        blink_off_q <= 1'b0;
      end

      if (ctrl_wr) begin
        if (run_start) begin
          state_q     <= ST_RUN;
          work_q      <= pattern_q;
          step_cnt_q  <= '0;
          dir_q       <= 1'b0;
          blink_off_q <= 1'b0;
        end else if (!writedata[CTRL_RUN]) begin
          state_q <= ST_IDLE;
        end
      end

      if (step) begin
        case (mode_q)
          MODE_ROT_L, MODE_ROT_R: begin
            if (mode_q == MODE_ROT_L) work_q <= {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            else                      work_q <= {work_q[0], work_q[WIDTH-1:1]};
            if (step_cnt_q == CNT_W'(WIDTH - 1)) begin
              step_cnt_q <= '0;
              wrap_q     <= 1'b1;
            end else begin
              step_cnt_q <= step_cnt_q + 1'b1;
            end
          end
          MODE_BOUNCE: begin
            if (!dir_q) begin
              if (work_q[WIDTH-1]) begin
                dir_q  <= 1'b1;
                work_q <= work_q >> 1;
                wrap_q <= 1'b1;
              end else begin
                work_q <= work_q << 1;
              end
            end else begin
              if (work_q[0]) begin
                dir_q  <= 1'b0;
                work_q <= work_q << 1;
                wrap_q <= 1'b1;
              end else begin
                work_q <= work_q >> 1;
              end
            end
          end
          MODE_BLINK: begin
            if (!blink_off_q) begin
              work_q      <= '0;
              blink_off_q <= 1'b1;
            end else begin
              work_q      <= pattern_q;
              blink_off_q <= 1'b0;
              wrap_q      <= 1'b1;
            end
          end
          default: ; // static and reserved modes hold the pattern
        endcase
      end
    end
  end

  assign out_port = work_q;

`ifdef LED_SEQ_IRQ_EN
  assign irq = wrap_q && irq_en_q;
`endif

  // Zero-wait-state read mux; unused bits read as 0
  // NOTE: readdata gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_PATTERN: readdata[WIDTH-1:0]    = pattern_q;
      ADDR_PERIOD:  readdata[PERIOD_W-1:0] = period_q;
      ADDR_CTRL: begin
        readdata[CTRL_RUN]                    = run_q;
        readdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
        readdata[CTRL_IRQ_EN]                 = irq_en_q;
      end
      ADDR_STATUS: begin
        readdata[STAT_RUNNING] = (state_q == ST_RUN);
        readdata[STAT_WRAP]    = wrap_q;
        readdata[STAT_DIR]     = dir_q;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed testbench for led_pattern_sequencer (default 8-bit, 24-bit period).
// The interrupt scenario is compiled only when LED_SEQ_IRQ_EN is defined.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] A_PATTERN = 2'd0;
  localparam logic [1:0] A_PERIOD  = 2'd1;
  localparam logic [1:0] A_CTRL    = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  led_pattern_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  // Single-cycle write; returns 1 time unit after the edge that performs it
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Zero-wait-state read sampled mid-cycle
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    #23;
    vectors++;
    if (out_port !== 8'h00) begin
      miscompares++; $display("FAIL reset_out: out_port=%h expected 00", out_port);
    end
    reset_n = 1'b1;
    bus_read(A_PERIOD, d);
    vectors++;
    if (d !== 32'd5000000) begin
      miscompares++; $display("FAIL reset_period: read=%0d expected 5000000", d);
    end
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++; $display("FAIL reset_ctrl: read=%h expected 0", d);
    end
    bus_read(A_STATUS, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++; $display("FAIL reset_status: read=%h expected 0", d);
    end
    bus_read(A_PATTERN, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++; $display("FAIL reset_pattern: read=%h expected 0", d);
    end
  endtask

  // Rotate left one position per cycle; wrap on the 8th step; stop write suppresses a step
  task automatic test_rot_l();
    logic [7:0]  exp;
    logic [31:0] d;
    bus_write(A_PATTERN, 32'h01);
    bus_write(A_PERIOD, 32'd0);
    bus_write(A_CTRL, 32'h03);
    address = A_STATUS;
    vectors++;
    if (out_port !== 8'h01) begin
      miscompares++; $display("FAIL rot_l_load: out_port=%h expected 01", out_port);
    end
    for (int i = 1; i <= 8; i++) begin
      next_edge();
      exp = 8'h01 << (i % 8);
      vectors++;
      if (out_port !== exp) begin
        miscompares++; $display("FAIL rot_l_step%0d: out_port=%h expected %h", i, out_port, exp);
      end
      vectors++;
      if (readdata[2:0] !== {1'b0, (i == 8), 1'b1}) begin
        miscompares++;
        $display("FAIL rot_l_status%0d: status=%b expected %b", i, readdata[2:0], {1'b0, (i == 8), 1'b1});
      end
    end
    bus_write(A_CTRL, 32'h00);
    vectors++;
    if (out_port !== 8'h01) begin
      miscompares++; $display("FAIL rot_l_stop_collision: out_port=%h expected 01", out_port);
    end
    bus_write(A_STATUS, 32'h2);
    bus_read(A_STATUS, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++; $display("FAIL rot_l_w1c: status=%h expected 0", d);
    end
  endtask

  // Bounce 0x81 with PERIOD=3: first tick after 4 cycles flips to right, 0x40
  task automatic test_bounce();
    logic [7:0] exp;
    bus_write(A_PATTERN, 32'h81);
    bus_write(A_PERIOD, 32'd3);
    bus_write(A_CTRL, 32'h07);
    address = A_STATUS;
    for (int k = 1; k <= 8; k++) begin
      next_edge();
      exp = (k < 4) ? 8'h81 : (k < 8) ? 8'h40 : 8'h20;
      vectors++;
      if (out_port !== exp) begin
        miscompares++; $display("FAIL bounce_cyc%0d: out_port=%h expected %h", k, out_port, exp);
      end
      vectors++;
      if (readdata[2:1] !== {(k >= 4), (k >= 4)}) begin
        miscompares++;
        $display("FAIL bounce_dirwrap%0d: dir,wrap=%b expected %b", k, readdata[2:1], {(k >= 4), (k >= 4)});
      end
    end
    bus_write(A_CTRL, 32'h00);
    bus_write(A_STATUS, 32'h2);
  endtask

  // All-ones bounce reverses on every tick
  task automatic test_bounce_all_ones();
    logic [7:0] exp;
    bus_write(A_PATTERN, 32'hFF);
    bus_write(A_PERIOD, 32'd0);
    bus_write(A_CTRL, 32'h07);
    for (int k = 1; k <= 3; k++) begin
      next_edge();
      exp = (k % 2 == 1) ? 8'h7F : 8'hFE;
      vectors++;
      if (out_port !== exp) begin
        miscompares++; $display("FAIL bounce_ones%0d: out_port=%h expected %h", k, out_port, exp);
      end
    end
    bus_write(A_CTRL, 32'h00);
    bus_write(A_STATUS, 32'h2);
  endtask

  // Blink 0xA5 with PERIOD=1; wrap on return; W1C clears, W1C on a wrap cycle loses
  task automatic test_blink();
    logic [7:0] exp;
    bus_write(A_PATTERN, 32'hA5);
    bus_write(A_PERIOD, 32'd1);
    bus_write(A_CTRL, 32'h09);
    address = A_STATUS;
    for (int k = 1; k <= 6; k++) begin
      next_edge();
      exp = ((k / 2) % 2 == 1) ? 8'h00 : 8'hA5;
      vectors++;
      if (out_port !== exp) begin
        miscompares++; $display("FAIL blink_cyc%0d: out_port=%h expected %h", k, out_port, exp);
      end
      vectors++;
      if (readdata[1] !== (k >= 4)) begin
        miscompares++; $display("FAIL blink_wrap%0d: wrap=%b expected %b", k, readdata[1], (k >= 4));
      end
    end
    bus_write(A_STATUS, 32'h2);
    address = A_STATUS;
    vectors++;
    if (readdata[1] !== 1'b0 || out_port !== 8'h00) begin
      miscompares++; $display("FAIL blink_w1c: wrap=%b out_port=%h expected 0 00", readdata[1], out_port);
    end
    bus_write(A_STATUS, 32'h2);
    address = A_STATUS;
    vectors++;
    if (readdata[1] !== 1'b1 || out_port !== 8'hA5) begin
      miscompares++; $display("FAIL blink_set_wins: wrap=%b out_port=%h expected 1 a5", readdata[1], out_port);
    end
    bus_write(A_CTRL, 32'h00);
    bus_write(A_STATUS, 32'h2);
  endtask

  // PATTERN write mid-run reloads; CTRL write while running suppresses that step
  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(A_PATTERN, 32'h01);
    bus_write(A_PERIOD, 32'd0);
    bus_write(A_CTRL, 32'h03);
    next_edge();
    vectors++;
    if (out_port !== 8'h02) begin
      miscompares++; $display("FAIL b2b_first_step: out_port=%h expected 02", out_port);
    end
    bus_write(A_PATTERN, 32'h3C);
    vectors++;
    if (out_port !== 8'h3C) begin
      miscompares++; $display("FAIL b2b_pattern_reload: out_port=%h expected 3c", out_port);
    end
    next_edge();
    vectors++;
    if (out_port !== 8'h78) begin
      miscompares++; $display("FAIL b2b_after_reload: out_port=%h expected 78", out_port);
    end
    bus_write(A_CTRL, 32'h03);
    vectors++;
    if (out_port !== 8'h78) begin
      miscompares++; $display("FAIL b2b_ctrl_collision: out_port=%h expected 78", out_port);
    end
    next_edge();
    vectors++;
    if (out_port !== 8'hF0) begin
      miscompares++; $display("FAIL b2b_resume: out_port=%h expected f0", out_port);
    end
    bus_write(A_CTRL, 32'h00);
    bus_read(A_PATTERN, d);
    vectors++;
    if (d !== 32'h3C) begin
      miscompares++; $display("FAIL b2b_pattern_read: read=%h expected 3c", d);
    end
    bus_write(A_STATUS, 32'h2);
  endtask

  // Interrupt enable bit: live with the macro, reads 0 without it
  task automatic test_irq();
    logic [31:0] d;
`ifdef LED_SEQ_IRQ_EN
    bus_write(A_PATTERN, 32'h0F);
    bus_write(A_PERIOD, 32'd0);
    bus_write(A_CTRL, 32'h19);
    next_edge();
    next_edge();
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++; $display("FAIL irq_assert: irq=%b expected 1", irq);
    end
    bus_write(A_STATUS, 32'h2);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("FAIL irq_clear: irq=%b expected 0", irq);
    end
    bus_write(A_CTRL, 32'h00);
    bus_write(A_STATUS, 32'h2);
`else
    bus_write(A_CTRL, 32'h18);
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h08) begin
      miscompares++; $display("FAIL ctrl_irq_en_absent: read=%h expected 08", d);
    end
    bus_write(A_CTRL, 32'h00);
`endif
  endtask

  // Asynchronous reset in the middle of a run returns everything to reset values
  task automatic test_reset_mid_run();
    bus_write(A_PATTERN, 32'h01);
    bus_write(A_PERIOD, 32'd0);
    bus_write(A_CTRL, 32'h03);
    next_edge();
    next_edge();
    #2;
    reset_n = 1'b0;
    address = A_STATUS;
    #1;
    vectors++;
    if (out_port !== 8'h00 || readdata !== 32'h0) begin
      miscompares++; $display("FAIL midrun_reset: out_port=%h status=%h expected 00 0", out_port, readdata);
    end
    address = A_PERIOD;
    #1;
    vectors++;
    if (readdata !== 32'd5000000) begin
      miscompares++; $display("FAIL midrun_reset_period: read=%0d expected 5000000", readdata);
    end
    #3;
    reset_n = 1'b1;
    next_edge();
    vectors++;
    if (out_port !== 8'h00) begin
      miscompares++; $display("FAIL midrun_reset_idle: out_port=%h expected 00", out_port);
    end
  endtask

  initial begin
    test_reset();
    test_rot_l();
    test_bounce();
    test_bounce_all_ones();
    test_blink();
    test_back_to_back();
    test_irq();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
